alu_op_sequencer: RTL and testbench

- Control and accumulator stage directly upstream of the ALU result multiplexer.
- Accepts one opcode plus a 16-bit operand per transaction over a valid/ready handshake.
- Drives the multiplexer's 12-bit one-hot select and the adder/subtractor mode line, and presents operands to the gate, shift and adder units.
- Holds the select stable for a programmable settle window, then captures the multiplexer result into an accumulator that feeds back as operand A.

---
 rtl/alu_op_sequencer.sv | 57 +++++
 tb/tb_alu_op_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts opcode/operand transactions, drives the result mux select for a settle window, then captures into the accumulator.
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand,
  output logic [11:0]      sel,
  output logic             sub,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] acc,
  output logic             res_valid,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, op;
  logic take, legal;
  always_comb begin
    take = op_valid && op_ready;
    legal = opcode < 4'd12;
    state_n = state == IDLE ? (take && legal ? DRIVE : IDLE) :
              state == DRIVE ? (cnt == 4'd0 ? CAPTURE : DRIVE) : IDLE;
    op_ready = state == IDLE;
    // select drops to zero in IDLE so each operation is a fresh transition
    sel = state == IDLE ? 12'd0 : 12'd1 << op;
    sub = sel == 12'h100;
    alu_a = acc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      alu_b <= '0;
      acc <= '0;
      res_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      res_valid <= state == CAPTURE;
      err <= take && !legal;
      if (take && legal) begin
        op <= opcode;
        alu_b <= operand;
        cnt <= 4'(SETTLE_CYCLES - 1);
      end else if (state == DRIVE && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == CAPTURE) acc <= op == 4'd11 ? '0 : alu_res;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scoreboard bench for two sequencer instances (settle 1 and settle 3).
module tb_alu_op_sequencer;
  typedef struct {bit is_err; logic [15:0] val;} exp_t;
  logic clk = 0, rst = 1;
  logic op_valid_a = 0, op_valid_b = 0;
  logic [3:0] opcode_a = 0, opcode_b = 0;
  logic [15:0] operand_a = 0, operand_b = 0;
  logic op_ready_a, op_ready_b, sub_a, sub_b, res_valid_a, res_valid_b, err_a, err_b;
  logic [11:0] sel_a, sel_b;
  logic [15:0] alu_a_a, alu_a_b, alu_b_a, alu_b_b, alu_res_a, alu_res_b, acc_a, acc_b;
  exp_t q_a[$], q_b[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] model(logic [11:0] s, logic [15:0] a, logic [15:0] b);
    case (s)
      12'h001: return a & b;
      12'h002: return a | b;
      12'h004: return ~a;
      12'h008: return a ^ b;
      12'h010: return ~(a & b);
      12'h020: return ~(a | b);
      12'h040: return ~(a ^ b);
      12'h080: return a + b;
      12'h100: return a - b;
      12'h200: return a >> 1;
      12'h400: return a << 1;
      12'h800: return 16'hBEEF;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign alu_res_a = model(sel_a, alu_a_a, alu_b_a);
  assign alu_res_b = model(sel_b, alu_a_b, alu_b_b);

  alu_op_sequencer #(.WIDTH(16), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .op_valid(op_valid_a), .op_ready(op_ready_a), .opcode(opcode_a),
    .operand(operand_a), .sel(sel_a), .sub(sub_a), .alu_a(alu_a_a), .alu_b(alu_b_a),
    .alu_res(alu_res_a), .acc(acc_a), .res_valid(res_valid_a), .err(err_a));

  alu_op_sequencer #(.WIDTH(16), .SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .op_valid(op_valid_b), .op_ready(op_ready_b), .opcode(opcode_b),
    .operand(operand_b), .sel(sel_b), .sub(sub_b), .alu_a(alu_a_b), .alu_b(alu_b_b),
    .alu_res(alu_res_b), .acc(acc_b), .res_valid(res_valid_b), .err(err_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitors: pop the scoreboard whenever a DUT reports a result or an error
  always @(negedge clk) begin
    exp_t e;
    if (res_valid_a === 1'b1 && err_a === 1'b1) chk("a_pulse_overlap", 1, 0);
    if (res_valid_a === 1'b1 || err_a === 1'b1) begin
      if (q_a.size() == 0) chk("a_unexpected_event", {res_valid_a, err_a}, 0);
      else begin
        e = q_a.pop_front();
        chk("a_event_kind", err_a, e.is_err);
        if (!e.is_err) chk("a_acc", acc_a, e.val);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (res_valid_b === 1'b1 && err_b === 1'b1) chk("b_pulse_overlap", 1, 0);
    if (res_valid_b === 1'b1 || err_b === 1'b1) begin
      if (q_b.size() == 0) chk("b_unexpected_event", {res_valid_b, err_b}, 0);
      else begin
        e = q_b.pop_front();
        chk("b_event_kind", err_b, e.is_err);
        if (!e.is_err) chk("b_acc", acc_b, e.val);
      end
    end
  end

  task automatic run_a(input logic [3:0] o, input logic [15:0] d, input logic [11:0] s, input logic [15:0] exp_acc);
    q_a.push_back('{0, exp_acc});
    op_valid_a = 1; opcode_a = o; operand_a = d;
    @(posedge clk); #1 op_valid_a = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("a_sel_op%0d_c%0d", o, i), sel_a, s);
      chk($sformatf("a_sub_op%0d_c%0d", o, i), sub_a, s == 12'h100);
      chk($sformatf("a_busy_op%0d_c%0d", o, i), op_ready_a, 0);
    end
    @(negedge clk);
    chk($sformatf("a_idle_sel_op%0d", o), sel_a, 0);
    chk($sformatf("a_ready_op%0d", o), op_ready_a, 1);
    chk($sformatf("a_res_valid_op%0d", o), res_valid_a, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", op_ready_a, 1);
    chk("rst_sel", sel_a, 0);
    chk("rst_acc", acc_a, 0);
    chk("rst_alu_b", alu_b_a, 0);
    chk("rst_pulses", {res_valid_a, err_a}, 0);
    // settle 3, op_valid held across both XORs
    q_b.push_back('{0, 16'h00FF});
    q_b.push_back('{0, 16'h0FF0});
    op_valid_b = 1; opcode_b = 4'd3; operand_b = 16'h00FF;
    @(posedge clk); #1 operand_b = 16'h0F0F;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk($sformatf("b_sel_op%0d_c%0d", k, i), sel_b, 12'h008);
        chk($sformatf("b_busy_op%0d_c%0d", k, i), op_ready_b, 0);
      end
      @(negedge clk);
      chk($sformatf("b_rv_ready_%0d", k), {res_valid_b, op_ready_b}, 2'b11);
      chk($sformatf("b_idle_sel_%0d", k), sel_b, 0);
      if (k == 1) op_valid_b = 0;
    end
    @(negedge clk);
    chk("b_no_third_accept", op_ready_b, 1);
    // settle 1 sequence
    run_a(4'd7, 16'h0005, 12'h080, 16'h0005);
    run_a(4'd8, 16'h0003, 12'h100, 16'h0002);
    chk("a_alu_a_after_sub", alu_a_a, 16'h0002);
    run_a(4'd11, 16'h00AA, 12'h800, 16'h0000);
    q_a.push_back('{1, 16'h0000});
    op_valid_a = 1; opcode_a = 4'hC; operand_a = 16'h1234;
    @(posedge clk); #1 op_valid_a = 0;
    @(negedge clk);
    chk("ill_err", err_a, 1);
    chk("ill_ready", op_ready_a, 1);
    chk("ill_sel", sel_a, 0);
    chk("ill_acc", acc_a, 0);
    chk("ill_alu_b", alu_b_a, 16'h00AA);
    @(negedge clk);
    chk("ill_err_single", {err_a, res_valid_a}, 0);
    run_a(4'd7, 16'h0010, 12'h080, 16'h0010);
    // abort an AND mid-DRIVE with reset
    op_valid_a = 1; opcode_a = 4'd0; operand_a = 16'hFFFF;
    @(posedge clk); #1 op_valid_a = 0;
    chk("abort_in_drive", sel_a, 12'h001);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_sel", sel_a, 0);
    chk("abort_acc", acc_a, 0);
    chk("abort_ready", op_ready_a, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet_%0d", i), {res_valid_a, err_a}, 0);
    end
    chk("scoreboard_a_drained", q_a.size(), 0);
    chk("scoreboard_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
